// File: rtl/seg_pkg.sv
// Shared display encodings: slot codes used by both the scan driver and the count selector,
// plus the active-low seven-segment pattern table.
package seg_pkg;

  localparam logic [1:0] SLOT0 = 2'b00;
  localparam logic [1:0] SLOT1 = 2'b01;
  localparam logic [1:0] SLOT2 = 2'b10;

  localparam logic [6:0] SEG_OFF = 7'b1111111;

  // Active-low gfedcba patterns, entry i is hex digit i.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };

endpackage

// File: rtl/seg_hex_decode.sv
// Combinational 4-bit hex to active-low seven-segment decoder.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 3-digit seven-segment scanner with per-slot blanking gap and optional
// leading-zero suppression; anodes and segments are registered one cycle behind the scan state.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int unsigned DIV   = 50000,
  parameter int unsigned BLANK = 1000,
  parameter int unsigned LZB   = 1
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       EN,
  input  logic [3:0] CNT1,
  input  logic [3:0] CNT2,
  input  logic [3:0] CNT3,
  output logic [1:0] SEL,
  output logic [2:0] AN,
  output logic [6:0] SEG,
  output logic       TICK
);

  localparam int unsigned CW = $clog2(DIV);

  logic [CW-1:0] cnt_q;
  logic [1:0]    sel_q, sel_next;
  logic          tick_q;
  logic [3:0]    lat0_q, lat1_q, lat2_q;
  logic [2:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic [3:0]    cur_digit;
  logic [6:0]    cur_seg;
  logic          last_cnt, blank_win, lz_blank;

  assign last_cnt  = (cnt_q == CW'(DIV - 1));
  assign blank_win = (cnt_q < CW'(BLANK));

  // Leading-zero suppression looks only at the frozen latches, never at the live inputs.
  assign lz_blank = (LZB != 0) &&
                    (((sel_q == SLOT2) && (lat2_q == 4'd0)) ||
                     ((sel_q == SLOT1) && (lat2_q == 4'd0) && (lat1_q == 4'd0)));

  always_comb begin
    cur_digit = lat0_q;
    sel_next  = SLOT0;
    unique case (sel_q)
      SLOT1: begin
        cur_digit = lat1_q;
        sel_next  = SLOT2;
      end
      SLOT2: begin
        cur_digit = lat2_q;
        sel_next  = SLOT0;
      end
      default: begin
        cur_digit = lat0_q;
        sel_next  = SLOT1;
      end
    endcase
  end

  seg_hex_decode u_dec (
    .hex (cur_digit),
    .seg (cur_seg)
  );

  always_comb begin
    an_d  = 3'b111;
    seg_d = SEG_OFF;
    if (!blank_win && !lz_blank) begin
      an_d  = ~(3'b001 << sel_q);
      seg_d = cur_seg;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt_q  <= '0;
      sel_q  <= SLOT0;
      tick_q <= 1'b0;
      lat0_q <= 4'd0;
      lat1_q <= 4'd0;
      lat2_q <= 4'd0;
      an_q   <= 3'b111;
      seg_q  <= SEG_OFF;
    end else if (EN) begin
      cnt_q  <= last_cnt ? '0 : cnt_q + CW'(1);
      sel_q  <= last_cnt ? sel_next : sel_q;
      tick_q <= last_cnt;
      if (blank_win) begin
        lat0_q <= CNT1;
        lat1_q <= CNT2;
        lat2_q <= CNT3;
      end
      an_q   <= an_d;
      seg_q  <= seg_d;
    end else begin
      tick_q <= 1'b0;
      an_q   <= 3'b111;
      seg_q  <= SEG_OFF;
    end
  end

  assign SEL  = sel_q;
  assign AN   = an_q;
  assign SEG  = seg_q;
  assign TICK = tick_q;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver with DIV=8, BLANK=2; one instance without and one with
// leading-zero blanking, driven from the same inputs.
module tb_seg_scan_driver;

  logic       CLK = 1'b0;
  logic       RST;
  logic       EN;
  logic [3:0] CNT1, CNT2, CNT3;
  logic [1:0] sel_a, sel_b;
  logic [2:0] an_a, an_b;
  logic [6:0] seg_a, seg_b;
  logic       tick_a, tick_b;

  int total = 0;
  int bad   = 0;

  always #5 CLK = ~CLK;

  seg_scan_driver #(.DIV(8), .BLANK(2), .LZB(0)) dut (
    .CLK (CLK), .RST (RST), .EN (EN),
    .CNT1 (CNT1), .CNT2 (CNT2), .CNT3 (CNT3),
    .SEL (sel_a), .AN (an_a), .SEG (seg_a), .TICK (tick_a)
  );

  seg_scan_driver #(.DIV(8), .BLANK(2), .LZB(1)) dut_lz (
    .CLK (CLK), .RST (RST), .EN (EN),
    .CNT1 (CNT1), .CNT2 (CNT2), .CNT3 (CNT3),
    .SEL (sel_b), .AN (an_b), .SEG (seg_b), .TICK (tick_b)
  );

  task automatic step(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic test_reset();
    RST = 1'b1; EN = 1'b1;
    CNT1 = 4'h3; CNT2 = 4'h7; CNT3 = 4'hA;
    step(2);
    RST = 1'b0;
    total++; if (sel_a !== 2'b00) begin bad++; $display("FAIL reset_sel got=%b want=00", sel_a); end
    total++; if (an_a !== 3'b111) begin bad++; $display("FAIL reset_an got=%b want=111", an_a); end
    total++;
    if (seg_a !== 7'b1111111) begin bad++; $display("FAIL reset_seg got=%b want=1111111", seg_a); end
    total++; if (tick_a !== 1'b0) begin bad++; $display("FAIL reset_tick got=%b want=0", tick_a); end
  endtask

  // From cnt=0/slot0: three full slots; after k edges cnt=k%8, slot=(k/8)%3.
  task automatic test_scan();
    logic [6:0] pats [3];
    int cnt, sl, pcnt, psl;
    logic [2:0] e_an;
    logic [6:0] e_seg;
    pats[0] = 7'b0110000; pats[1] = 7'b1111000; pats[2] = 7'b0001000;
    for (int k = 1; k <= 24; k++) begin
      step(1);
      cnt = k % 8; sl = (k / 8) % 3;
      pcnt = (k - 1) % 8; psl = ((k - 1) / 8) % 3;
      e_an  = (pcnt < 2) ? 3'b111 : ~(3'b001 << psl);
      e_seg = (pcnt < 2) ? 7'b1111111 : pats[psl];
      total++;
      if (sel_a !== 2'(sl)) begin bad++; $display("FAIL scan_sel k=%0d got=%b want=%0d", k, sel_a, sl); end
      total++;
      if (tick_a !== (cnt == 0)) begin
        bad++; $display("FAIL scan_tick k=%0d got=%b want=%0d", k, tick_a, (cnt == 0));
      end
      total++;
      if (an_a !== e_an) begin bad++; $display("FAIL scan_an k=%0d got=%b want=%b", k, an_a, e_an); end
      total++;
      if (seg_a !== e_seg) begin bad++; $display("FAIL scan_seg k=%0d got=%b want=%b", k, seg_a, e_seg); end
    end
  endtask

  // Starts at cnt=0/slot0; ends at cnt=3/slot0.
  task automatic test_midslot();
    step(4);
    CNT1 = 4'h5;
    for (int i = 0; i < 4; i++) begin
      step(1);
      total++;
      if (seg_a !== 7'b0110000) begin bad++; $display("FAIL mid_hold i=%0d got=%b want=0110000", i, seg_a); end
      total++;
      if (an_a !== 3'b110) begin bad++; $display("FAIL mid_an i=%0d got=%b want=110", i, an_a); end
    end
    step(16 + 3);
    total++;
    if (seg_a !== 7'b0010010) begin bad++; $display("FAIL mid_new got=%b want=0010010", seg_a); end
  endtask

  // Starts at cnt=3/slot0; ends at cnt=3/slot2.
  task automatic test_lzb();
    CNT1 = 4'h0; CNT2 = 4'h0; CNT3 = 4'h0;
    step(5 + 3);
    total++; if (an_b !== 3'b111) begin bad++; $display("FAIL lz_s1_an got=%b want=111", an_b); end
    total++;
    if (seg_b !== 7'b1111111) begin bad++; $display("FAIL lz_s1_seg got=%b want=1111111", seg_b); end
    total++; if (an_a !== 3'b101) begin bad++; $display("FAIL nolz_s1_an got=%b want=101", an_a); end
    total++;
    if (seg_a !== 7'b1000000) begin bad++; $display("FAIL nolz_s1_seg got=%b want=1000000", seg_a); end
    step(8);
    total++; if (an_b !== 3'b111) begin bad++; $display("FAIL lz_s2_an got=%b want=111", an_b); end
    total++; if (sel_b !== 2'b10) begin bad++; $display("FAIL lz_s2_sel got=%b want=10", sel_b); end
    step(8);
    total++; if (an_b !== 3'b110) begin bad++; $display("FAIL lz_s0_an got=%b want=110", an_b); end
    total++;
    if (seg_b !== 7'b1000000) begin bad++; $display("FAIL lz_s0_seg got=%b want=1000000", seg_b); end
    CNT2 = 4'h4;
    step(5 + 3);
    total++; if (an_b !== 3'b101) begin bad++; $display("FAIL lz4_s1_an got=%b want=101", an_b); end
    total++;
    if (seg_b !== 7'b0011001) begin bad++; $display("FAIL lz4_s1_seg got=%b want=0011001", seg_b); end
    step(8);
    total++; if (an_b !== 3'b111) begin bad++; $display("FAIL lz4_s2_an got=%b want=111", an_b); end
  endtask

  // Starts at cnt=3/slot2; ends at cnt=0/slot2.
  task automatic test_enable();
    step(5 + 8 + 5);
    total++; if (sel_a !== 2'b01) begin bad++; $display("FAIL en_pre_sel got=%b want=01", sel_a); end
    EN = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      total++;
      if (an_a !== 3'b111) begin bad++; $display("FAIL en_off_an i=%0d got=%b want=111", i, an_a); end
      total++;
      if (sel_a !== 2'b01) begin bad++; $display("FAIL en_off_sel i=%0d got=%b want=01", i, sel_a); end
      total++;
      if (tick_a !== 1'b0) begin bad++; $display("FAIL en_off_tick i=%0d got=%b want=0", i, tick_a); end
    end
    EN = 1'b1;
    step(1);
    total++; if (an_a !== 3'b101) begin bad++; $display("FAIL en_relit_an got=%b want=101", an_a); end
    step(1);
    total++; if (sel_a !== 2'b01) begin bad++; $display("FAIL en_c7_sel got=%b want=01", sel_a); end
    step(1);
    total++; if (sel_a !== 2'b10) begin bad++; $display("FAIL en_adv_sel got=%b want=10", sel_a); end
    total++; if (tick_a !== 1'b1) begin bad++; $display("FAIL en_adv_tick got=%b want=1", tick_a); end
  endtask

  task automatic test_mid_reset();
    step(6);
    RST = 1'b1;
    step(1);
    RST = 1'b0;
    total++; if (sel_a !== 2'b00) begin bad++; $display("FAIL rst_sel got=%b want=00", sel_a); end
    total++; if (an_a !== 3'b111) begin bad++; $display("FAIL rst_an got=%b want=111", an_a); end
    total++;
    if (seg_a !== 7'b1111111) begin bad++; $display("FAIL rst_seg got=%b want=1111111", seg_a); end
    total++; if (tick_a !== 1'b0) begin bad++; $display("FAIL rst_tick got=%b want=0", tick_a); end
    for (int i = 1; i <= 2; i++) begin
      step(1);
      total++;
      if (an_a !== 3'b111) begin bad++; $display("FAIL rst_gap i=%0d got=%b want=111", i, an_a); end
    end
    step(1);
    total++; if (an_a !== 3'b110) begin bad++; $display("FAIL rst_lit_an got=%b want=110", an_a); end
    total++;
    if (seg_a !== 7'b1000000) begin bad++; $display("FAIL rst_lit_seg got=%b want=1000000", seg_a); end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_midslot();
    test_lzb();
    test_enable();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_driver.md
Name: seg_scan_driver

Overview:
Time-multiplexed driver for the 3-digit seven-segment display. It produces the 2-bit digit-select code consumed by the count selector (00/01/10 → CNT1/CNT2/CNT3) and scans the digits in a fixed rotation. It drives the active-low digit anodes and active-low segments, with a blanking gap at every digit change to prevent ghosting.
It sits between the counter/selector datapath and the board display pins.

Parameters:
DIV, 50000, clock cycles per digit slot; must satisfy DIV ≥ 4.
BLANK, 1000, cycles at the start of each slot with all anodes off; must satisfy 1 ≤ BLANK < DIV.
LZB, 1, when 1, leading zeros in digits 2 and 1 are blanked.

Ports:
CLK  input  1  system clock; everything is on the rising edge.
RST  input  1  synchronous, active-high reset.
EN  input  1  scan enable.
CNT1  input  4  digit 0 value (least significant, rightmost).
CNT2  input  4  digit 1 value.
CNT3  input  4  digit 2 value (most significant).
SEL  output  2  current slot code: 00, 01 or 10. Feeds the selector's SW input.
AN  output  3  active-low anodes; AN[i] lights digit i.
SEG  output  7  active-low segments; bit0=a … bit6=g.
TICK  output  1  one-cycle pulse on the cycle SEL changes.

Behaviour:
- Interface: one clock, CLK. RST is synchronous and active-high.
- Reset (RST=1 at an edge):
  - cnt=0, SEL=00, TICK=0.
  - AN=3'b111, SEG=7'b1111111.
  - Digit latches cleared to 0.
  - Reset mid-slot aborts the slot immediately.
- Prescaler cnt, width clog2(DIV):
  - With EN=1, counts 0..DIV-1.
  - At cnt==DIV-1: cnt←0, SEL advances 00→01→10→00, TICK=1 for that next cycle.
  - SEL never takes 11.
- EN=0:
  - cnt, SEL and the latches hold; TICK=0.
  - AN forced to 111 on the next edge.
  - On re-enable, counting resumes from the held cnt. There is no slot restart.
- Latching: on every EN=1 cycle with cnt<BLANK, all three digit latches sample CNT1..3. They are frozen while cnt≥BLANK, so input changes mid-slot never glitch the display.
- Output registration: AN and SEG are registers. Their value in cycle t+1 is a function of cnt, SEL and the latches in cycle t (1-cycle latency).
  - Blank window (cnt<BLANK): AN=111, SEG=1111111.
  - Otherwise: AN = ~(1<<SEL), SEG = decode(latch[SEL]).
- Decode is full hex (active-low, gfedcba):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
- Leading-zero blanking (LZB=1), evaluated on the latched values:
  - Digit 2 is blanked when latch2==0.
  - Digit 1 is blanked when latch2==0 and latch1==0.
  - Digit 0 is never blanked.
  - A blanked slot drives AN=111, SEG=1111111 for the whole slot; SEL and TICK still advance.
- Simultaneous RST and EN: RST wins.

Decomposition:
- Shared package seg_pkg:
  - Slot codes SLOT0=2'b00, SLOT1=2'b01, SLOT2=2'b10. These are shared with the selector so the encodings cannot drift.
  - Constant SEG_OFF=7'b1111111 and the 16-entry active-low segment pattern table.
- Sub-module seg_hex_decode: combinational 4-bit → 7-bit active-low decoder. It is reused by the other display blocks.

Test Plan:
- DIV=8, BLANK=2, LZB=0, EN=1; CNT1=3, CNT2=7, CNT3=A.
  - SEL cycles 00,01,10 every 8 cycles; TICK pulses at each change.
  - Per slot: 2 cycles AN=111, then 6 cycles with AN=110/SEG=0110000, then AN=101/SEG=1111000, then AN=011/SEG=0001000.
- Mid-slot input change: change CNT1 3→5 at cnt=4 of slot 0.
  - SEG stays 0110000 for the rest of the slot.
  - The next slot-0 visit shows 0010010.
- LZB=1, CNT3=0, CNT2=0, CNT1=0: slots 1 and 2 are fully blank (AN=111); slot 0 shows 1000000.
  - With CNT2=4 instead: slot 1 shows 0011001, slot 2 stays blank.
- EN dropped for 5 cycles at cnt=5 of slot 1: AN=111 from the next edge, SEL holds at 01.
  - After re-enable, the slot completes after 2 more counts (cnt 6,7); then SEL=10.
- RST asserted at cnt=6 of slot 2: on the next edge SEL=00, AN=111, SEG=1111111, TICK=0.
  - The first lit output appears 3 cycles after RST deasserts.
